// File: rtl/lcd_cfah_ctrl_if.sv
// Request/response channel between the display sequencer (master) and the
// CFAH LCD bus controller (slave).
interface lcd_cfah_ctrl_if;
  logic       i_req_val;
  logic       o_req_rdy;
  logic       i_req_rs;
  logic       i_req_rw;
  logic [7:0] i_req_data;
  logic [7:0] o_rsp_data;
  logic       o_rsp_val;
  logic       o_busy;

  modport master (
    output i_req_val, i_req_rs, i_req_rw, i_req_data,
    input  o_req_rdy, o_rsp_data, o_rsp_val, o_busy
  );

  modport slave (
    input  i_req_val, i_req_rs, i_req_rw, i_req_data,
    output o_req_rdy, o_rsp_data, o_rsp_val, o_busy
  );
endinterface

// File: rtl/lcd_cfah_ctrl.sv
// CFAH (HD44780-style, 8-bit) character LCD bus initiator.
// Runs one RS/RW/EN/DB cycle per accepted request with cycle-counted
// tAS / PWEH / tAH / tcycE timing, then an execution wait for writes.
// Optional macro LCD_CFAH_BUSY_POLL_EN: replaces the fixed execution wait
// with busy-flag polling (internal instruction reads until DB7 reads 0).
module lcd_cfah_ctrl #(
  parameter int unsigned T_AS_CYC        = 4,
  parameter int unsigned T_PWEH_CYC      = 23,
  parameter int unsigned T_AH_CYC        = 1,
  parameter int unsigned T_CYCE_CYC      = 50,
  parameter int unsigned T_EXEC_CYC      = 4000,
  parameter int unsigned T_EXEC_LONG_CYC = 152000
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_cfah_ctrl_if.slave   req,
  output logic             o_rs,
  output logic             o_rw,
  output logic             o_en,
  inout  logic [7:0]       io_data
);

  // Remaining gap so that EN rise-to-rise spacing reaches T_CYCE_CYC.
  localparam int unsigned CYC_WAIT = (T_CYCE_CYC > T_PWEH_CYC + T_AH_CYC) ?
                                     (T_CYCE_CYC - T_PWEH_CYC - T_AH_CYC) : 0;
  localparam int unsigned MAX_0   = (T_AS_CYC > T_PWEH_CYC) ? T_AS_CYC : T_PWEH_CYC;
  localparam int unsigned MAX_1   = (MAX_0 > T_AH_CYC) ? MAX_0 : T_AH_CYC;
  localparam int unsigned MAX_2   = (MAX_1 > CYC_WAIT) ? MAX_1 : CYC_WAIT;
  localparam int unsigned MAX_3   = (MAX_2 > T_EXEC_CYC) ? MAX_2 : T_EXEC_CYC;
  localparam int unsigned CNT_MAX = (MAX_3 > T_EXEC_LONG_CYC) ? MAX_3 : T_EXEC_LONG_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_CYCLE, ST_EXEC
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rs_q, rs_d, rw_q, rw_d, en_q, en_d;
  logic               rdy_q, rdy_d, busy_q, busy_d, drv_q, drv_d;
  logic               rsp_val_q, rsp_val_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               lat_rs_q, lat_rs_d, lat_rw_q, lat_rw_d;
  logic [7:0]         lat_data_q, lat_data_d;
  logic               cyc_done;
  logic               cnt_last;
`ifdef LCD_CFAH_BUSY_POLL_EN
  logic               poll_q, poll_d, bf_q, bf_d;
`endif

  assign cnt_last = (cnt_q == CNT_W'(1));

  // Next-state, counter and pin computation for the bus FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    en_d       = en_q;
    rdy_d      = 1'b0;
    rsp_val_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    lat_rs_d   = lat_rs_q;
    lat_rw_d   = lat_rw_q;
    lat_data_d = lat_data_q;
    cyc_done   = 1'b0;
`ifdef LCD_CFAH_BUSY_POLL_EN
    poll_d     = poll_q;
    bf_d       = bf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        en_d  = 1'b0;
        rw_d  = 1'b1;
        rdy_d = 1'b1;
        if (req.i_req_val && rdy_q) begin
          lat_rs_d   = req.i_req_rs;
          lat_rw_d   = req.i_req_rw;
          lat_data_d = req.i_req_data;
          rs_d       = req.i_req_rs;
          rw_d       = req.i_req_rw;
          rdy_d      = 1'b0;
          cnt_d      = CNT_W'(T_AS_CYC);
          state_d    = ST_SETUP;
`ifdef LCD_CFAH_BUSY_POLL_EN
          poll_d     = 1'b0;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          en_d    = 1'b1;
          cnt_d   = CNT_W'(T_PWEH_CYC);
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_last) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(T_AH_CYC);
          state_d = ST_HOLD;
          if (lat_rw_q) begin
`ifdef LCD_CFAH_BUSY_POLL_EN
            if (poll_q) begin
              bf_d = io_data[7];
            end else begin
              rsp_data_d = io_data;
              rsp_val_d  = 1'b1;
            end
`else
            rsp_data_d = io_data;
            rsp_val_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          if (CYC_WAIT == 0) begin
            cyc_done = 1'b1;
          end else begin
            cnt_d   = CNT_W'(CYC_WAIT);
            state_d = ST_CYCLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CYCLE: begin
        if (cnt_last) cyc_done = 1'b1;
        else          cnt_d    = cnt_q - CNT_W'(1);
      end
      ST_EXEC: begin
        if (cnt_last) begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving CYCLE (or HOLD when no extra gap is needed); RW returns high.
    if (cyc_done) begin
      rw_d = 1'b1;
      if (!lat_rw_q) begin
`ifdef LCD_CFAH_BUSY_POLL_EN
        // A write is followed by busy-flag reads reusing the normal bus cycle.
        poll_d   = 1'b1;
        lat_rs_d = 1'b0;
        lat_rw_d = 1'b1;
        rs_d     = 1'b0;
        cnt_d    = CNT_W'(T_AS_CYC);
        state_d  = ST_SETUP;
`else
        state_d = ST_EXEC;
        if (!lat_rs_q && (lat_data_q inside {8'h01, 8'h02, 8'h03}))
          cnt_d = CNT_W'(T_EXEC_LONG_CYC);
        else
          cnt_d = CNT_W'(T_EXEC_CYC);
`endif
      end else begin
`ifdef LCD_CFAH_BUSY_POLL_EN
        if (poll_q && bf_q) begin
          cnt_d   = CNT_W'(T_AS_CYC);
          state_d = ST_SETUP;
        end else begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end
`else
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
`endif
      end
    end

    busy_d = (state_d != ST_IDLE);
    drv_d  = !rw_d && (state_d inside {ST_SETUP, ST_PULSE, ST_HOLD});
  end

  // State and registered pin/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b1;
      en_q       <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      drv_q      <= 1'b0;
      rsp_val_q  <= 1'b0;
      rsp_data_q <= '0;
      lat_rs_q   <= 1'b0;
      lat_rw_q   <= 1'b1;
      lat_data_q <= '0;
`ifdef LCD_CFAH_BUSY_POLL_EN
      poll_q     <= 1'b0;
      bf_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      drv_q      <= drv_d;
      rsp_val_q  <= rsp_val_d;
      rsp_data_q <= rsp_data_d;
      lat_rs_q   <= lat_rs_d;
      lat_rw_q   <= lat_rw_d;
      lat_data_q <= lat_data_d;
`ifdef LCD_CFAH_BUSY_POLL_EN
      poll_q     <= poll_d;
      bf_q       <= bf_d;
`endif
    end
  end

  assign o_rs           = rs_q;
  assign o_rw           = rw_q;
  assign o_en           = en_q;
  assign io_data        = drv_q ? lat_data_q : 8'bz;
  assign req.o_req_rdy  = rdy_q;
  assign req.o_busy     = busy_q;
  assign req.o_rsp_val  = rsp_val_q;
  assign req.o_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// Directed bench for lcd_cfah_ctrl with a small LCD emulator on the pins.
// The clear-command wait is shortened through a parameter override so the
// run stays short; all other timing uses the default values.
module tb_lcd_cfah_ctrl;
  localparam int unsigned AS  = 4;
  localparam int unsigned PW  = 23;
  localparam int unsigned AH  = 1;
  localparam int unsigned CE  = 50;
  localparam int unsigned EX  = 4000;
  localparam int unsigned EXL = 15200;
  localparam int unsigned CW  = 26;                 // 50 - 23 - 1
  localparam int unsigned RD_POST = AH + CW;        // 27
`ifdef LCD_CFAH_BUSY_POLL_EN
  localparam int unsigned POLL_LEN = AS + PW + AH + CW;  // 54
  localparam int unsigned WR_POST  = AH + CW + POLL_LEN; // 81, one idle poll
  localparam int unsigned CLR_POST = WR_POST;
  localparam int unsigned WR_POLLS = 1;
`else
  localparam int unsigned WR_POST  = AH + CW + EX;       // 4027
  localparam int unsigned CLR_POST = AH + CW + EXL;      // 15227
  localparam int unsigned WR_POLLS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       o_rs, o_rw, o_en;
  wire  [7:0] io_data;

  lcd_cfah_ctrl_if req_if ();

  lcd_cfah_ctrl #(
    .T_AS_CYC(AS), .T_PWEH_CYC(PW), .T_AH_CYC(AH), .T_CYCE_CYC(CE),
    .T_EXEC_CYC(EX), .T_EXEC_LONG_CYC(EXL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req_if),
    .o_rs(o_rs), .o_rw(o_rw), .o_en(o_en), .io_data(io_data)
  );

  always #5 clk = ~clk;

  // Undriven bus reads as 0xFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (io_data[g]);
  end

  // LCD emulator: drives DB during read pulses, captures write bytes on EN fall.
  logic [7:0] emu_rd_data = 8'h00;
  int         busy_left = 0;
  logic [7:0] cap[$];
  assign io_data = (o_rw && o_en) ?
                   (o_rs ? emu_rd_data : ((busy_left > 0) ? 8'h80 : 8'h00)) : 8'bz;
  always @(negedge o_en) begin
    if (!o_rw) cap.push_back(io_data);
    else if (!o_rs && busy_left > 0) busy_left--;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned last_rise = 0;
  int unsigned rise_gap = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One full request: handshake, setup/pulse/post timing, data and response.
  task automatic run_txn(input logic rs, input logic rw, input logic [7:0] data,
                         input int unsigned exp_post, input int unsigned exp_polls,
                         input bit poke, input string tag);
    int unsigned n, rises, rsp_cnt;
    logic [7:0]  db_last, rsp_seen;
    logic        en_prev;
    n = 0;
    while (!req_if.o_req_rdy && n < 200000) begin @(negedge clk); n++; end
    chk({tag, ".rdy"}, req_if.o_req_rdy, 1'b1);
    req_if.i_req_rs   = rs;
    req_if.i_req_rw   = rw;
    req_if.i_req_data = data;
    req_if.i_req_val  = 1'b1;
    @(negedge clk);
    req_if.i_req_val = 1'b0;
    chk({tag, ".busy"}, req_if.o_busy, 1'b1);
    chk({tag, ".rdy_drop"}, req_if.o_req_rdy, 1'b0);
    chk({tag, ".rs_rw"}, {o_rs, o_rw}, {rs, rw});
    chk({tag, ".setup_db"}, io_data, rw ? 8'hFF : data);
    n = 0;
    while (!o_en && n < 1000) begin n++; @(negedge clk); end
    chk({tag, ".tas"}, n, AS);
    rise_gap  = cyc - last_rise;
    last_rise = cyc;
    n = 0;
    db_last = 8'h00;
    while (o_en && n < 1000) begin n++; db_last = io_data; @(negedge clk); end
    chk({tag, ".pweh"}, n, PW);
    chk({tag, ".pulse_db"}, db_last, rw ? emu_rd_data : data);
    n = 0; rises = 0; rsp_cnt = 0; en_prev = 1'b0; rsp_seen = 8'h00;
    while (!req_if.o_req_rdy && n < 200000) begin
      n++;
      if (req_if.o_rsp_val) begin rsp_cnt++; rsp_seen = req_if.o_rsp_data; end
      if (o_en && !en_prev) begin
        rises++;
        chk({tag, ".poll_pins"}, {o_rs, o_rw}, 2'b01);
      end
      en_prev = o_en;
      req_if.i_req_data = 8'hEE;
      req_if.i_req_val  = poke;
      @(negedge clk);
    end
    req_if.i_req_val = 1'b0;
    chk({tag, ".post"}, n, exp_post);
    chk({tag, ".polls"}, rises, exp_polls);
    chk({tag, ".rsp_cnt"}, rsp_cnt, rw ? 1 : 0);
    if (rw) chk({tag, ".rsp_data"}, rsp_seen, data);
    if (poke) begin
      @(negedge clk);
      chk({tag, ".no_queue"}, req_if.o_busy, 1'b0);
    end
  endtask

  initial begin
    int unsigned n;
    req_if.i_req_val  = 1'b0;
    req_if.i_req_rs   = 1'b0;
    req_if.i_req_rw   = 1'b0;
    req_if.i_req_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.rdy", req_if.o_req_rdy, 1'b0);
    chk("rst.busy", req_if.o_busy, 1'b0);
    chk("rst.pins", {o_rs, o_rw, o_en}, 3'b010);
    chk("rst.rsp", {req_if.o_rsp_val, req_if.o_rsp_data}, 9'h000);
    chk("rst.db", io_data, 8'hFF);
    rst_n = 1'b1;
    #1 chk("rel.rdy0", req_if.o_req_rdy, 1'b0);
    @(negedge clk);
    chk("rel.rdy1", req_if.o_req_rdy, 1'b1);

    // Function set instruction write.
    run_txn(1'b0, 1'b0, 8'h38, WR_POST, WR_POLLS, 1'b0, "wr38");
    chk("wr38.cap_n", cap.size(), 1);
    chk("wr38.cap", (cap.size() > 0) ? cap[0] : 8'h00, 8'h38);
    cap.delete();

    // Back-to-back data writes.
    run_txn(1'b1, 1'b0, 8'h41, WR_POST, WR_POLLS, 1'b0, "wr41");
    run_txn(1'b1, 1'b0, 8'h42, WR_POST, WR_POLLS, 1'b0, "wr42");
    chk("b2b.gap", rise_gap, PW + 1 + AS + WR_POST);
    chk("b2b.gap_min", rise_gap >= CE, 1'b1);
    chk("b2b.cap_n", cap.size(), 2);
    chk("b2b.cap0", (cap.size() > 0) ? cap[0] : 8'h00, 8'h41);
    chk("b2b.cap1", (cap.size() > 1) ? cap[1] : 8'h00, 8'h42);
    cap.delete();

    // Data read: emulator supplies 0x5A, no execution wait.
    emu_rd_data = 8'h5A;
    run_txn(1'b1, 1'b1, 8'h5A, RD_POST, 0, 1'b0, "rd5a");
    chk("rd5a.cap_n", cap.size(), 0);

    // Clear display with a competing request held during the long wait.
    run_txn(1'b0, 1'b0, 8'h01, CLR_POST, WR_POLLS, 1'b1, "clr");
    cap.delete();

    // Reset in the middle of an EN pulse.
    req_if.i_req_rs = 1'b0; req_if.i_req_rw = 1'b0; req_if.i_req_data = 8'h38;
    req_if.i_req_val = 1'b1;
    @(negedge clk);
    req_if.i_req_val = 1'b0;
    n = 0;
    while (!o_en && n < 1000) begin n++; @(negedge clk); end
    repeat (5) @(negedge clk);
    chk("mid.en_hi", o_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.pins", {o_en, o_rw}, 2'b01);
    chk("mid.db", io_data, 8'hFF);
    chk("mid.rdy_busy", {req_if.o_req_rdy, req_if.o_busy}, 2'b00);
    chk("mid.rsp_data", req_if.o_rsp_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid.rdy0", req_if.o_req_rdy, 1'b0);
    @(negedge clk);
    chk("mid.rdy1", req_if.o_req_rdy, 1'b1);
    cap.delete();
    run_txn(1'b0, 1'b0, 8'h38, WR_POST, WR_POLLS, 1'b0, "after_rst");
    chk("after_rst.cap", (cap.size() > 0) ? cap[0] : 8'h00, 8'h38);

`ifdef LCD_CFAH_BUSY_POLL_EN
    // Busy flag reads 0x80 twice, then 0x00.
    busy_left = 2;
    run_txn(1'b1, 1'b0, 8'h43, AH + CW + 3 * POLL_LEN, 3, 1'b0, "poll");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_cfah_ctrl.md
Name: lcd_cfah_ctrl

Overview:
- Host-side initiator for the CFAH character LCD parallel bus (HD44780-style, 8-bit).
- Accepts one command/data request at a time over a valid/ready handshake.
- Generates RS/RW/EN/DB with cycle-counted tAS, PWEH, tAH and tcycE timing; returns read data.
- Sits between the display sequencer and the pads; the LCD_CFAH emulator-checker is its bench counterpart.

Parameters:
- T_AS_CYC, 4, clk cycles RS/RW/DB stable before EN rises (40 ns at 100 MHz); legal 1..255.
- T_PWEH_CYC, 23, clk cycles EN held high (230 ns); legal 1..255.
- T_AH_CYC, 1, clk cycles RS/RW/DB held after EN falls; legal 1..255.
- T_CYCE_CYC, 50, minimum clk cycles between successive EN rising edges (500 ns).
- T_EXEC_CYC, 4000, post-write execution wait (40 us).
- T_EXEC_LONG_CYC, 152000, wait after an instruction write with data 0x01, 0x02 or 0x03 (clear/home, 1.52 ms).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_req_val  input  1  request valid.
- o_req_rdy  output  1  block idle, can accept a request.
- i_req_rs  input  1  0 = instruction, 1 = data register.
- i_req_rw  input  1  0 = write, 1 = read.
- i_req_data  input  8  write data (ignored for reads).
- o_rsp_data  output  8  data captured on a read.
- o_rsp_val  output  1  one-cycle pulse, o_rsp_data valid.
- o_busy  output  1  transaction or execution wait in progress.
- o_rs  output  1  LCD RS pin.
- o_rw  output  1  LCD RW pin.
- o_en  output  1  LCD E pin.
- io_data  inout  8  LCD DB[7:0].

Behaviour:
- Reset (async, immediate, including mid-transaction): o_rs=0, o_rw=1, o_en=0, io_data=Z, o_req_rdy=0, o_busy=0, o_rsp_val=0, o_rsp_data=0x00, state=IDLE, counters=0. o_req_rdy rises on the first clk edge after reset release.
- Handshake: accept when i_req_val && o_req_rdy at a clk edge; latch rs/rw/data; o_req_rdy drops next cycle and o_busy rises. i_req_val while not ready is ignored, with no queuing.
- All pin outputs are registered.
- io_data is driven with the latched data only while o_rw=0 and the state is SETUP, PULSE or HOLD; otherwise Z.
- FSM:
  - IDLE: o_en=0, o_rw=1, o_req_rdy=1; on accept go to SETUP.
  - SETUP: o_rs/o_rw take the latched values on entry; o_en=0 for exactly T_AS_CYC cycles; then PULSE.
  - PULSE: o_en=1 for exactly T_PWEH_CYC cycles. For reads, io_data is sampled on the last PULSE edge into o_rsp_data, with o_rsp_val=1 for the following cycle. Then HOLD.
  - HOLD: o_en=0, rs/rw/data held for T_AH_CYC cycles; then CYCLE.
  - CYCLE: wait until at least T_CYCE_CYC cycles have elapsed since the EN rise, counted as max(0, T_CYCE_CYC − T_PWEH_CYC − T_AH_CYC) cycles. Then EXEC for writes, IDLE for reads. o_rw returns to 1 on leaving CYCLE.
  - EXEC: o_rw=1, bus Z, wait T_EXEC_CYC cycles, or T_EXEC_LONG_CYC when latched rs=0 and data ∈ {0x01, 0x02, 0x03}; then IDLE.
- o_busy = (state != IDLE).
- EN rise-to-rise spacing is ≥ T_CYCE_CYC for back-to-back requests, guaranteed by CYCLE.
- Counters are sized to the largest parameter; they load at state entry and count down to 1.

Optional Feature:
- Macro: LCD_CFAH_BUSY_POLL_EN.
- Defined:
  - EXEC is replaced by busy-flag polling: internal read cycles with rs=0, rw=1, using identical SETUP/PULSE/HOLD/CYCLE timing.
  - If the sampled io_data[7]=1, repeat the poll; if 0, go to IDLE.
  - Poll reads never assert o_rsp_val; T_EXEC_CYC and T_EXEC_LONG_CYC are unused.
- Undefined: fixed EXEC timers as above; no poll logic is synthesised.

Test Plan:
- Write instruction 0x38 (rs=0, rw=0) → o_rs=0, o_rw=0; EN high exactly 23 cycles; EN rises 4 cycles after RS/RW settle; emulator o_rdata=0x38; o_req_rdy returns after EXEC of 4000 cycles.
- Write data 0x41 (rs=1), immediately followed by a second data write 0x42 → EN rise-to-rise ≥ 50 cycles plus EXEC; emulator reports no tAS/tPWEH/tAH errors; bytes 0x41 then 0x42 captured.
- Read with i_wdata=0x5A (rs=1, rw=1) → io_data not driven by the controller; o_rsp_val pulses once with o_rsp_data=0x5A; no EXEC wait.
- Write 0x01 (clear) → o_busy held 152000 cycles after CYCLE; a request during that time is not accepted.
- Assert rst_n=0 mid-PULSE → o_en=0, io_data=Z, o_rw=1 immediately (same timestep); after release o_req_rdy=1 one cycle later, and a new write completes normally.
- With LCD_CFAH_BUSY_POLL_EN: emulator returns 0x80 twice then 0x00 → exactly 3 poll EN pulses with rs=0, rw=1; o_rsp_val never asserted; returns to IDLE.
